// File: rtl/serial_aru_pkg.sv
// Shared definitions for the bit-serial arithmetic unit: default sizing,
// operation encodings and FSM state encoding.
package serial_aru_pkg;

  localparam int WORD_LENGTH_DEF  = 20;
  localparam int FLYBACK_TIME_DEF = 2;

  localparam logic [1:0] OP_PASS_A = 2'd0;
  localparam logic [1:0] OP_SUB    = 2'd1;
  localparam logic [1:0] OP_NEG    = 2'd2;
  localparam logic [1:0] OP_PASS_S = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    FLYBACK = 2'd2
  } state_e;

  // Counter must index both the word bits and the flyback beats; never
  // narrower than one bit.
  function automatic int cnt_width(input int wl, input int ft);
    int m;
    m = (wl > ft) ? wl : ft;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_full_adder.sv
// One-bit sum/carry cell; inv_b_i turns it into a subtractor stage.
module serial_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic inv_b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic b_eff;

  // Plain combinational full adder with optional operand inversion.
  always_comb begin
    b_eff   = b_i ^ inv_b_i;
    sum_o   = a_i ^ b_eff ^ c_i;
    carry_o = (a_i & b_eff) | (a_i & c_i) | (b_eff & c_i);
  end

endmodule

// File: rtl/serial_aru.sv
// Bit-serial arithmetic unit feeding the accumulator. The WORD_START beat
// carries bit 0; results are registered, so the ACTIVE beats coincide with
// the beats on which ARU_DATA_OUT carries result bits 0..WORD_LENGTH-1.
module serial_aru
  import serial_aru_pkg::*;
#(
  parameter int WORD_LENGTH  = WORD_LENGTH_DEF,
  parameter int FLYBACK_TIME = FLYBACK_TIME_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WORD_START,
  input  logic [1:0] OP,
  input  logic       A_DATA,
  input  logic       S_DATA,
  output logic       ARU_DATA_OUT,
  output logic       ARU_VALID,
  output logic       RESULT_NEG,
  output logic       RESULT_ZERO,
  output logic       WORD_DONE,
  output logic       OVERRUN
);

  localparam int CW = cnt_width(WORD_LENGTH, FLYBACK_TIME);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LENGTH - 1);
  localparam logic [CW-1:0] LAST_FLY = CW'(FLYBACK_TIME - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          carry_q, carry_d;
  logic          zacc_q, zacc_d;
  logic          out_q, out_d;
  logic          neg_q, neg_d;
  logic          zero_q, zero_d;
  logic          ovr_q, ovr_d;

  logic       start, proc, last_bit;
  logic [1:0] op_eff;
  logic       fa_a, fa_inv, fa_cin, fa_sum, fa_cout, res_bit;

  // Bit 0 is computed on the WORD_START beat itself, so the live OP and a
  // forced carry-in of 1 are used there instead of the latched copies.
  always_comb begin
    start    = (state_q == IDLE) && WORD_START;
    last_bit = (state_q == ACTIVE) && (cnt_q == LAST_BIT);
    proc     = start || ((state_q == ACTIVE) && !last_bit);
    op_eff   = start ? OP : op_q;
    fa_cin   = start ? 1'b1 : carry_q;
    fa_a     = (op_eff == OP_NEG) ? 1'b0 : A_DATA;
    fa_inv   = (op_eff == OP_SUB) || (op_eff == OP_NEG);
  end

  serial_full_adder u_fa (
    .a_i     (fa_a),
    .b_i     (S_DATA),
    .inv_b_i (fa_inv),
    .c_i     (fa_cin),
    .sum_o   (fa_sum),
    .carry_o (fa_cout)
  );

  // Select the result bit for the current operation.
  always_comb begin
    unique case (op_eff)
      OP_PASS_A: res_bit = A_DATA;
      OP_PASS_S: res_bit = S_DATA;
      default:   res_bit = fa_sum;
    endcase
  end

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    out_d   = 1'b0;
    neg_d   = neg_q;
    zero_d  = zero_q;
    ovr_d   = ovr_q | (WORD_START && (state_q != IDLE));

    if (proc) begin
      out_d   = res_bit;
      carry_d = fa_cout;
      zacc_d  = (start ? 1'b0 : zacc_q) | res_bit;
    end

    unique case (state_q)
      IDLE: begin
        if (WORD_START) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          op_d    = OP;
        end
      end
      ACTIVE: begin
        if (last_bit) begin
          // out_q holds the MSB on this beat; zacc_q already covers it.
          neg_d   = out_q;
          zero_d  = ~zacc_q;
          cnt_d   = '0;
          state_d = (FLYBACK_TIME == 0) ? IDLE : FLYBACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLYBACK: begin
        if (cnt_q == LAST_FLY) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_PASS_A;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      out_q   <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      out_q   <= out_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ARU_DATA_OUT = out_q;
  assign ARU_VALID    = (state_q == ACTIVE);
  assign WORD_DONE    = last_bit;
  assign RESULT_NEG   = neg_q;
  assign RESULT_ZERO  = zero_q;
  assign OVERRUN      = ovr_q;

endmodule
